load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage responder to the pipeline's memory-control signals (store-enable, load/store class, funct3 width).
- Converts one M-stage load/store into a single word-wide request/response transaction on the data-memory port. Generates byte enables and store lane steering, and aligns and sign-extends load data for writeback.
- Drives `mem_stall` to hold the pipeline while a transaction is outstanding.

Parameters:
- DATAW, 32, data width in bits; fixed at 32 for RV32 (byte-lane logic assumes 4 lanes).
- ADDRW, 32, byte-address width of the M-stage effective address.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- is_load_m  in  1  M-stage instruction is a load
- is_store_m  in  1  M-stage instruction is a store (same meaning as the mem write-enable)
- funct3_m  in  3  M-stage funct3 (access width/sign)
- addr_m  in  ADDRW  effective byte address (ALU result)
- store_data_m  in  DATAW  rs2 value, already bypassed
- pipe_stall  in  1  stall from other hazard sources; M-stage instruction is held
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=write, 0=read
- mem_req_addr  out  ADDRW-2  word address (addr_m[ADDRW-1:2])
- mem_req_wdata  out  DATAW  lane-steered store data
- mem_req_be  out  DATAW/8  byte enables
- mem_resp_valid  in  1  response/ack, one cycle per accepted request
- mem_resp_rdata  in  DATAW  read word
- load_data  out  DATAW  aligned, extended load result, registered
- mem_stall  out  1  hold pipeline (combinational)
- misalign_err  out  1  see optional feature; tied 0 when disabled

Behaviour:
Reset values:
- FSM = IDLE.
- mem_req_valid = 0, load_data = 0, misalign_err = 0.
- mem_stall = 0 while reset is high.

mem_op:
- mem_op = is_load_m | is_store_m.
- If both are high, treat as store.

FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_op, go to REQ next cycle.
  - mem_stall = mem_op.
- REQ:
  - mem_req_valid = 1.
  - Address, we, be and wdata are stable until accepted.
  - On mem_req_valid & mem_req_ready, go to WAIT.
  - mem_stall = 1.
- WAIT:
  - mem_stall = !mem_resp_valid.
  - On mem_resp_valid:
    - For a load, capture the extended result into load_data.
    - If pipe_stall is high that cycle, go to DONE; otherwise go to IDLE.
- DONE:
  - The same instruction is still held by pipe_stall.
  - Issue no new request; mem_stall = 0; load_data is held.
  - Return to IDLE on the first cycle with pipe_stall low.

Timing and response rules:
- Minimum latency is 3 cycles from mem_op to the mem_stall-low cycle: IDLE, then REQ with ready=1, then WAIT with an immediate response.
- Responses arrive no earlier than the cycle after acceptance.
- mem_resp_valid in IDLE, REQ or DONE is ignored.
- load_data changes only on a captured load response.

Byte enables and store data, by funct3[1:0] with o = addr_m[1:0]:
- SB (0): be = 1<<o; wdata = {4{sd[7:0]}}.
- SH (1): be = 3<<(2*o[1]); wdata = {2{sd[15:0]}}.
- SW (2/3): be = 4'hF; wdata = sd.
- Loads: be = 4'hF.

Load extraction from rdata:
- The byte or half is selected by o (half uses o[1]).
- funct3 0 (LB) and 1 (LH): sign-extend.
- funct3 4 (LBU) and 5 (LHU): zero-extend.
- funct3 2, 3, 6 and 7: full word.

Misalignment handling without the feature:
- Low address bits are truncated to natural alignment: a half uses o[1] only, a word ignores o.

Reset mid-transaction:
- Return to IDLE and drop valid the same cycle.
- A late response after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - A misaligned access is half with o[0]=1, or word with o≠0.
  - It issues no request.
  - misalign_err pulses for exactly 1 cycle, in the IDLE cycle where the access is detected.
  - mem_stall stays 0 and the FSM stays in IDLE.
  - load_data is unchanged.
- Disabled: truncation as above; misalign_err is constant 0.

Test Plan:
1. LW at addr 0x1000, ready=1 immediately, resp one cycle later with rdata=0xDEADBEEF:
   - req_addr = 0x400, be = F.
   - mem_stall high for 2 cycles.
   - load_data = 0xDEADBEEF.
2. LB at addr 0x1003, rdata=0x80FF7F01 -> load_data = 0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x1002 -> 0xFFFF80FF.
3. SB at addr 0x2001, store_data=0x000000A5:
   - be = 4'b0010, wdata = 0xA5A5A5A5, we = 1.
   - load_data unchanged.
4. ready held low 3 cycles in REQ:
   - valid, addr and be stay stable.
   - Exactly one accept occurs.
   - mem_stall is not released until resp_valid.
5. pipe_stall high for 2 cycles after resp_valid:
   - FSM sits in DONE.
   - No second mem_req_valid.
   - Returns to IDLE when pipe_stall drops.
6. Reset asserted in WAIT, then resp_valid arrives:
   - valid = 0, FSM = IDLE.
   - Response ignored; load_data = 0.
   - With LSU_MISALIGN_TRAP_EN, LW at 0x1002 gives a one-cycle misalign_err pulse and no request.

Source files
------------

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one word-wide request/response per access.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit #(
    parameter int DATAW = 32,
    parameter int ADDRW = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_load_m,
    input  logic                 is_store_m,
    input  logic [2:0]           funct3_m,
    input  logic [ADDRW-1:0]     addr_m,
    input  logic [DATAW-1:0]     store_data_m,
    input  logic                 pipe_stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDRW-3:0]     mem_req_addr,
    output logic [DATAW-1:0]     mem_req_wdata,
    output logic [DATAW/8-1:0]   mem_req_be,
    input  logic                 mem_resp_valid,
    input  logic [DATAW-1:0]     mem_resp_rdata,
    output logic [DATAW-1:0]     load_data,
    output logic                 mem_stall,
    output logic                 misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state;
    logic                 mem_op;
    logic                 mis;
    logic [1:0]           off;
    logic [DATAW/8-1:0]   be_c;
    logic [DATAW-1:0]     wdata_c;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [7:0]           byte_c;
    logic [15:0]          half_c;
    logic [DATAW-1:0]     ext_c;

    assign mem_op = is_load_m | is_store_m;
    assign off    = addr_m[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = mem_op
               & (((funct3_m[1:0] == 2'd1) & off[0])
               | (funct3_m[1] & (off != 2'd0)));
    assign misalign_err = !reset & (state == S_IDLE) & mis;
`else
    assign mis = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        be_c    = '1;
        wdata_c = store_data_m;
        if (is_store_m) begin
            unique case (funct3_m[1:0])
                2'd0: begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{store_data_m[7:0]}};
                end
                2'd1: begin
                    be_c    = off[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{store_data_m[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign byte_c = mem_resp_rdata[{off_q, 3'b000} +: 8];
    assign half_c = off_q[1] ? mem_resp_rdata[31:16]
                             : mem_resp_rdata[15:0];

    always_comb begin
        ext_c = mem_resp_rdata;
        unique case (f3_q)
            3'd0:    ext_c = {{24{byte_c[7]}}, byte_c};
            3'd1:    ext_c = {{16{half_c[15]}}, half_c};
            3'd4:    ext_c = {24'd0, byte_c};
            3'd5:    ext_c = {16'd0, half_c};
            default: ext_c = mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            load_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mem_op && !mis) begin
                        state         <= S_REQ;
                        mem_req_we    <= is_store_m;
                        mem_req_addr  <= addr_m[ADDRW-1:2];
                        mem_req_be    <= be_c;
                        mem_req_wdata <= wdata_c;
                        f3_q          <= funct3_m;
                        off_q         <= off;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!mem_req_we)
                            load_data <= ext_c;
                        state <= pipe_stall ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!pipe_stall)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid = !reset & (state == S_REQ);

    always_comb begin
        mem_stall = 1'b0;
        if (!reset) begin
            unique case (state)
                S_IDLE:  mem_stall = mem_op & !mis;
                S_REQ:   mem_stall = 1'b1;
                S_WAIT:  mem_stall = !mem_resp_valid;
                default: mem_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    logic        clock = 0;
    logic        reset;
    logic        is_load_m, is_store_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, store_data_m;
    logic        pipe_stall;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] load_data;
    logic        mem_stall, misalign_err;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .is_load_m(is_load_m), .is_store_m(is_store_m),
        .funct3_m(funct3_m), .addr_m(addr_m),
        .store_data_m(store_data_m), .pipe_stall(pipe_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .load_data(load_data), .mem_stall(mem_stall),
        .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    logic [29:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    bit          chk_en = 0;
    bit          exp_stall, exp_valid, exp_we, exp_err;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;

    task automatic check(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
        end
    endtask

    function automatic logic [3:0] m_be(bit st, logic [2:0] f3, logic [1:0] o);
        if (!st || f3[1]) return 4'hF;
        if (f3[0]) return 4'(3 << (2 * o[1]));
        return 4'(1 << o);
    endfunction

    function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] sd);
        if (f3[1]) return sd;
        if (f3[0]) return sd[15:0] * 32'h0001_0001;
        return sd[7:0] * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] m_ld(logic [2:0] f3, logic [1:0] o, logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * o)) & 32'hFF;
                if (f3 == 3'd0 && v[7]) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * o[1])) & 32'hFFFF;
                if (f3 == 3'd1 && v[15]) v = v - 32'h1_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic bit m_mis(logic [2:0] f3, logic [1:0] o);
`ifdef LSU_MISALIGN_TRAP_EN
        return (f3[1:0] == 2'd1 && o[0]) || (f3[1] && o != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clock) begin
        if (mem_req_valid && mem_req_ready) begin
            accepts++;
            last_addr  = mem_req_addr;
            last_be    = mem_req_be;
            last_wdata = mem_req_wdata;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall", mem_stall, exp_stall);
            check("valid", mem_req_valid, exp_valid);
            check("load_data", load_data, exp_ld);
            check("misalign_err", misalign_err, exp_err);
            if (exp_valid) begin
                check("we", mem_req_we, exp_we);
                check("addr", mem_req_addr, exp_addr);
                check("be", mem_req_be, exp_be);
                if (exp_we) check("wdata", mem_req_wdata, exp_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            is_load_m = 0; is_store_m = 0;
            mem_resp_valid = 1'($urandom);
            mem_resp_rdata = $urandom;
            pipe_stall = 1'($urandom);
            mem_req_ready = 1'($urandom);
            exp_stall = 0; exp_valid = 0; exp_err = 0;
            tick();
        end
        mem_resp_valid = 0;
        pipe_stall = 0;
    endtask

    task automatic run_op(bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                          logic [31:0] sd, logic [31:0] rd,
                          int rdly, int wdly, int ps);
        bit mis;
        int acc0;
        acc0 = accepts;
        mis = m_mis(f3, a[1:0]);
        is_load_m = ld; is_store_m = st; funct3_m = f3;
        addr_m = a; store_data_m = sd;
        pipe_stall = 0; mem_resp_valid = 0;
        mem_req_ready = 1'($urandom);
        exp_valid = 0; exp_err = mis; exp_stall = !mis;
        tick();
        exp_err = 0;
        if (!mis) begin
            for (int i = 0; i <= rdly; i++) begin
                mem_req_ready = (i == rdly);
                exp_valid = 1; exp_stall = 1; exp_we = st;
                exp_addr = a[31:2];
                exp_be = m_be(st, f3, a[1:0]);
                exp_wdata = m_wd(f3, sd);
                tick();
            end
            exp_valid = 0;
            for (int j = 0; j <= wdly; j++) begin
                mem_req_ready = 1'($urandom);
                mem_resp_valid = (j == wdly);
                mem_resp_rdata = (j == wdly) ? rd : $urandom;
                pipe_stall = (j == wdly) ? (ps > 0) : 1'($urandom);
                exp_stall = (j != wdly);
                tick();
            end
            mem_resp_valid = 0;
            if (!st) exp_ld = m_ld(f3, a[1:0], rd);
            for (int k = 0; k < ps; k++) begin
                pipe_stall = (k < ps - 1);
                exp_stall = 0;
                tick();
            end
            pipe_stall = 0;
        end
        check("accepts", accepts - acc0, mis ? 0 : 1);
        is_load_m = 0; is_store_m = 0;
        exp_stall = 0;
    endtask

    initial begin
        reset = 1;
        is_load_m = 1; is_store_m = 0; funct3_m = 3'd2;
        addr_m = 0; store_data_m = 0; pipe_stall = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        exp_stall = 0; exp_valid = 0; exp_err = 0; exp_ld = 0;
        exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        reset = 0; is_load_m = 0;
        idle(2);

        run_op(1, 0, 3'd2, 32'h1000, 0, 32'hDEADBEEF, 0, 0, 0);
        check("t1 load_data", load_data, 32'hDEADBEEF);
        check("t1 addr", last_addr, 30'h400);
        check("t1 be", last_be, 4'hF);

        run_op(1, 0, 3'd0, 32'h1003, 0, 32'h80FF7F01, 0, 1, 0);
        check("t2 lb", load_data, 32'hFFFFFF80);
        run_op(1, 0, 3'd4, 32'h1003, 0, 32'h80FF7F01, 1, 0, 0);
        check("t2 lbu", load_data, 32'h00000080);
        run_op(1, 0, 3'd1, 32'h1002, 0, 32'h80FF7F01, 0, 0, 0);
        check("t2 lh", load_data, 32'hFFFF80FF);

        run_op(0, 1, 3'd0, 32'h2001, 32'h000000A5, 32'h11111111, 0, 0, 0);
        check("t3 be", last_be, 4'b0010);
        check("t3 wdata", last_wdata, 32'hA5A5A5A5);
        check("t3 load_data", load_data, 32'hFFFF80FF);

        run_op(0, 1, 3'd1, 32'h2006, 32'h0000BEEF, 0, 3, 2, 0);
        check("t4 be", last_be, 4'b1100);
        run_op(1, 0, 3'd5, 32'h2002, 0, 32'hC0DE1234, 0, 0, 2);
        check("t5 lhu", load_data, 32'h0000C0DE);
        idle(1);

        // reset while waiting for a response, then a late response
        is_load_m = 1; funct3_m = 3'd2; addr_m = 32'h3000;
        exp_stall = 1; exp_valid = 0;
        tick();
        mem_req_ready = 1;
        exp_valid = 1; exp_we = 0; exp_addr = 30'hC00; exp_be = 4'hF;
        tick();
        mem_req_ready = 0; exp_valid = 0; exp_stall = 1;
        tick();
        reset = 1; exp_stall = 0;
        tick();
        reset = 0; is_load_m = 0; exp_ld = 0;
        mem_resp_valid = 1; mem_resp_rdata = 32'h12345678;
        tick();
        mem_resp_valid = 0;
        check("t6 load_data", load_data, 32'h0);

        // reset while a request is pending must drop valid at once
        is_load_m = 1; addr_m = 32'h3004;
        exp_stall = 1;
        tick();
        exp_valid = 1; exp_addr = 30'hC01;
        tick();
        reset = 1; exp_valid = 0; exp_stall = 0;
        tick();
        reset = 0; is_load_m = 0;
        idle(2);

        run_op(1, 0, 3'd2, 32'h1002, 0, 32'hCAFEF00D, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t7 load_data", load_data, 32'h0);
`else
        check("t7 load_data", load_data, 32'hCAFEF00D);
        check("t7 addr", last_addr, 30'h400);
`endif

        for (int n = 0; n < 300; n++) begin
            bit ld, st;
            ld = 1'($urandom);
            st = ld ? ($urandom_range(0, 3) == 0) : 1'b1;
            run_op(ld, st, 3'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
